// File: rtl/pci_pkg.sv
// Shared command codes, target state encoding and decode helper for the PCI config target.
package pci_pkg;

    localparam logic [3:0] CMD_CFG_READ  = 4'b1010;
    localparam logic [3:0] CMD_CFG_WRITE = 4'b1011;

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        RACC,
        RWAIT,
        RDATA,
        WDATA,
        WSTB,
        TURN
    } state_e;

    // True for the two Type-0 configuration commands this target answers.
    function automatic logic is_cfg_cmd(input logic [3:0] cbe_n);
        return (cbe_n == CMD_CFG_READ) || (cbe_n == CMD_CFG_WRITE);
    endfunction

endpackage

// File: rtl/pci_par_gen.sv
// PAR generation: even parity over the AD/C-BE# values driven this cycle,
// presented on the following clock together with a one-cycle-delayed enable.
module pci_par_gen
    import pci_pkg::*;
#(
    parameter bit PAR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ad,
    input  logic [3:0]  cbe_n,
    input  logic        ad_oe,
    output logic        par_out,
    output logic        par_oe
);

    logic par_d, par_q;
    logic oe_d, oe_q;

    // Next parity bit and enable; both forced low when parity generation is disabled.
    always_comb begin
        par_d = PAR_EN ? ^{ad, cbe_n} : 1'b0;
        oe_d  = PAR_EN ? ad_oe : 1'b0;
    end

    // Parity lags AD by one clock, so PAR stays driven one clock after AD is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
            oe_q  <= 1'b0;
        end else begin
            par_q <= par_d;
            oe_q  <= oe_d;
        end
    end

    assign par_out = par_q;
    assign par_oe  = oe_q;

endmodule

// File: rtl/pci_cfg_target.sv
// PCI Type-0 configuration target: claims single-dword config reads/writes,
// runs DEVSEL#/TRDY#/STOP# and hands one request per transaction to pci_cfg.
module pci_cfg_target
    import pci_pkg::*;
#(
    parameter logic [2:0] FUNC_NUM = 3'd0,
    parameter bit         PAR_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_n,
    input  logic        irdy_n,
    input  logic        idsel,
    input  logic [3:0]  cbe_n,
    input  logic [31:0] ad_in,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        par_out,
    output logic        par_oe,
    output logic        devsel_n_out,
    output logic        trdy_n_out,
    output logic        stop_n_out,
    output logic        ctl_oe,
    output logic        cfg_enable,
    output logic        cfg_iswrite,
    output logic [5:0]  cfg_offset,
    output logic [31:0] cfg_write_val,
    input  logic [31:0] cfg_read_val
);

    state_e      state_d, state_q;
    logic        ctl_oe_d, ctl_oe_q;
    logic        devsel_n_d, devsel_n_q;
    logic        trdy_n_d, trdy_n_q;
    logic        stop_n_d, stop_n_q;
    logic        ad_oe_d, ad_oe_q;
    logic        cfg_enable_d, cfg_enable_q;
    logic        cfg_iswrite_d, cfg_iswrite_q;
    logic [5:0]  cfg_offset_d, cfg_offset_q;
    logic [31:0] cfg_write_val_d, cfg_write_val_q;
    logic [31:0] ad_out_d, ad_out_q;
    logic        claim;

    // Next state and datapath captures; bus controls are decoded from the next
    // state so every output leaves a flop and matches the state it belongs to.
    always_comb begin
        claim = idsel && (ad_in[1:0] == 2'b00) && (ad_in[10:8] == FUNC_NUM)
                && is_cfg_cmd(cbe_n);

        state_d         = state_q;
        cfg_iswrite_d   = cfg_iswrite_q;
        cfg_offset_d    = cfg_offset_q;
        cfg_write_val_d = cfg_write_val_q;
        ad_out_d        = ad_out_q;

        case (state_q)
            IDLE: begin
                if (!frame_n) begin
                    if (claim) begin
                        cfg_offset_d  = ad_in[7:2];
                        cfg_iswrite_d = cbe_n[0];
                        state_d       = cbe_n[0] ? WDATA : RACC;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            // Someone else's transaction (or our disconnected burst): wait for bus idle.
            BUSY: begin
                if (frame_n && irdy_n) state_d = IDLE;
            end
            RACC:  state_d = RWAIT;
            RWAIT: begin
                ad_out_d = cfg_read_val;
                state_d  = RDATA;
            end
            RDATA: begin
                if (!irdy_n) state_d = TURN;
            end
            // Byte enables are ignored: pci_cfg only takes whole dwords.
            WDATA: begin
                if (!irdy_n) begin
                    cfg_write_val_d = ad_in;
                    state_d         = WSTB;
                end
            end
            WSTB, TURN: state_d = frame_n ? IDLE : BUSY;
            default:    state_d = IDLE;
        endcase

        ctl_oe_d     = state_d inside {RACC, RWAIT, RDATA, WDATA, WSTB, TURN};
        devsel_n_d   = !(state_d inside {RACC, RWAIT, RDATA, WDATA});
        trdy_n_d     = !(state_d inside {RDATA, WDATA});
        // Disconnect-with-data whenever the master still signals more phases.
        stop_n_d     = !((state_d inside {RDATA, WDATA}) && !frame_n);
        ad_oe_d      = (state_d == RDATA);
        cfg_enable_d = state_d inside {RACC, WSTB};
    end

    // State and registered outputs; reset releases the bus asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            ctl_oe_q        <= 1'b0;
            devsel_n_q      <= 1'b1;
            trdy_n_q        <= 1'b1;
            stop_n_q        <= 1'b1;
            ad_oe_q         <= 1'b0;
            cfg_enable_q    <= 1'b0;
            cfg_iswrite_q   <= 1'b0;
            cfg_offset_q    <= 6'd0;
            cfg_write_val_q <= 32'd0;
            ad_out_q        <= 32'd0;
        end else begin
            state_q         <= state_d;
            ctl_oe_q        <= ctl_oe_d;
            devsel_n_q      <= devsel_n_d;
            trdy_n_q        <= trdy_n_d;
            stop_n_q        <= stop_n_d;
            ad_oe_q         <= ad_oe_d;
            cfg_enable_q    <= cfg_enable_d;
            cfg_iswrite_q   <= cfg_iswrite_d;
            cfg_offset_q    <= cfg_offset_d;
            cfg_write_val_q <= cfg_write_val_d;
            ad_out_q        <= ad_out_d;
        end
    end

    pci_par_gen #(
        .PAR_EN (PAR_EN)
    ) u_par_gen (
        .clk     (clk),
        .rst     (rst),
        .ad      (ad_out_q),
        .cbe_n   (cbe_n),
        .ad_oe   (ad_oe_q),
        .par_out (par_out),
        .par_oe  (par_oe)
    );

    assign ad_out        = ad_out_q;
    assign ad_oe         = ad_oe_q;
    assign ctl_oe        = ctl_oe_q;
    assign devsel_n_out  = devsel_n_q;
    assign trdy_n_out    = trdy_n_q;
    assign stop_n_out    = stop_n_q;
    assign cfg_enable    = cfg_enable_q;
    assign cfg_iswrite   = cfg_iswrite_q;
    assign cfg_offset    = cfg_offset_q;
    assign cfg_write_val = cfg_write_val_q;

endmodule

// File: tb/tb_pci_cfg_target.sv
// Directed bench for pci_cfg_target with a small pci_cfg register model and a
// scoreboard of expected cfg requests.
module tb_pci_cfg_target;
    import pci_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_n, irdy_n, idsel;
    logic [3:0]  cbe_n;
    logic [31:0] ad_in;
    logic [31:0] ad_out;
    logic        ad_oe, par_out, par_oe;
    logic        devsel_n_out, trdy_n_out, stop_n_out, ctl_oe;
    logic        cfg_enable, cfg_iswrite;
    logic [5:0]  cfg_offset;
    logic [31:0] cfg_write_val;
    logic [31:0] cfg_read_val = 32'd0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        iswrite;
        logic [5:0]  offset;
        logic [31:0] wval;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        sb_e;
    logic [31:0] cfg_mem [0:63];

    always #5 clk = ~clk;

    pci_cfg_target #(
        .FUNC_NUM (3'd0),
        .PAR_EN   (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst_n),
        .frame_n       (frame_n),
        .irdy_n        (irdy_n),
        .idsel         (idsel),
        .cbe_n         (cbe_n),
        .ad_in         (ad_in),
        .ad_out        (ad_out),
        .ad_oe         (ad_oe),
        .par_out       (par_out),
        .par_oe        (par_oe),
        .devsel_n_out  (devsel_n_out),
        .trdy_n_out    (trdy_n_out),
        .stop_n_out    (stop_n_out),
        .ctl_oe        (ctl_oe),
        .cfg_enable    (cfg_enable),
        .cfg_iswrite   (cfg_iswrite),
        .cfg_offset    (cfg_offset),
        .cfg_write_val (cfg_write_val),
        .cfg_read_val  (cfg_read_val)
    );

    // pci_cfg model: read data appears one clock after the request strobe.
    always @(posedge clk) begin
        if (cfg_enable && !cfg_iswrite) cfg_read_val <= cfg_mem[cfg_offset];
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk32(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic chk_bus(input string tag, input logic c, input logic dv, input logic tr,
                           input logic ao);
        chk1({tag, "_ctl_oe"}, ctl_oe, c);
        chk1({tag, "_devsel_n"}, devsel_n_out, dv);
        chk1({tag, "_trdy_n"}, trdy_n_out, tr);
        chk1({tag, "_ad_oe"}, ad_oe, ao);
    endtask

    // Scoreboard: every cfg_enable pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (rst_n && cfg_enable) begin
            chk1("sb_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                chk1("sb_iswrite", cfg_iswrite, sb_e.iswrite);
                chk32("sb_offset", {26'd0, cfg_offset}, {26'd0, sb_e.offset});
                if (sb_e.iswrite) chk32("sb_wval", cfg_write_val, sb_e.wval);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        frame_n = 1'b1; irdy_n = 1'b1; idsel = 1'b0; cbe_n = 4'hF; ad_in = 32'd0;
    endtask

    task automatic addr_phase(input logic [3:0] cmd, input logic [31:0] a, input logic sel);
        frame_n = 1'b0; irdy_n = 1'b1; idsel = sel; cbe_n = cmd; ad_in = a;
    endtask

    task automatic push(input logic w, input logic [5:0] off, input logic [31:0] v);
        exp_t e;
        e.iswrite = w; e.offset = off; e.wval = v;
        exp_q.push_back(e);
    endtask

    // Single-phase read with 'waits' IRDY# wait states once TRDY# is asserted.
    task automatic read_txn(input logic [5:0] off, input logic [31:0] val, input int waits);
        push(1'b0, off, 32'd0);
        addr_phase(CMD_CFG_READ, {24'd0, off, 2'b00}, 1'b1);
        step();
        chk_bus("rd_racc", 1'b1, 1'b0, 1'b1, 1'b0);
        chk1("rd_racc_en", cfg_enable, 1'b1);
        frame_n = 1'b1; irdy_n = 1'b1; idsel = 1'b0; cbe_n = 4'h0; ad_in = 32'd0;
        step();
        chk_bus("rd_rwait", 1'b1, 1'b0, 1'b1, 1'b0);
        chk1("rd_rwait_en", cfg_enable, 1'b0);
        step();
        for (int i = 0; i <= waits; i++) begin
            chk_bus("rd_data", 1'b1, 1'b0, 1'b0, 1'b1);
            chk32("rd_ad_out", ad_out, val);
            chk1("rd_stop_n", stop_n_out, 1'b1);
            chk1("rd_en_quiet", cfg_enable, 1'b0);
            if (i > 0) chk1("rd_par_oe_data", par_oe, 1'b1);
            if (i == waits) irdy_n = 1'b0;
            step();
        end
        chk_bus("rd_turn", 1'b1, 1'b1, 1'b1, 1'b0);
        chk1("rd_turn_par_oe", par_oe, 1'b1);
        chk1("rd_turn_par", par_out, ^{val, 4'h0});
        irdy_n = 1'b1;
        step();
        chk_bus("rd_idle", 1'b0, 1'b1, 1'b1, 1'b0);
        chk1("rd_idle_par_oe", par_oe, 1'b0);
    endtask

    logic        nc_sel [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  nc_cmd [4] = '{4'b1010, 4'b0110, 4'b1010, 4'b1010};
    logic [31:0] nc_ad  [4] = '{32'h0, 32'h0, 32'h100, 32'h1};

    initial begin
        for (int i = 0; i < 64; i++) cfg_mem[i] = 32'd0;
        cfg_mem[0] = 32'h12345678;
        cfg_mem[2] = 32'hA5A50F0F;
        cfg_mem[3] = 32'h0F1E2D3C;
        cfg_mem[4] = 32'hCAFEF00D;

        // Reset state
        rst_n = 1'b0;
        idle_bus();
        step();
        step();
        chk_bus("rst", 1'b0, 1'b1, 1'b1, 1'b0);
        chk1("rst_stop_n", stop_n_out, 1'b1);
        chk1("rst_par_oe", par_oe, 1'b0);
        chk1("rst_par_out", par_out, 1'b0);
        chk1("rst_cfg_enable", cfg_enable, 1'b0);
        chk1("rst_cfg_iswrite", cfg_iswrite, 1'b0);
        chk32("rst_cfg_offset", {26'd0, cfg_offset}, 32'd0);
        chk32("rst_cfg_write_val", cfg_write_val, 32'd0);
        chk32("rst_ad_out", ad_out, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: zero-wait config read of offset 0
        read_txn(6'd0, 32'h12345678, 0);

        // 2: config write of offset 1
        push(1'b1, 6'h01, 32'hDEADBEEF);
        addr_phase(CMD_CFG_WRITE, 32'h00000004, 1'b1);
        step();
        chk_bus("wr_wdata", 1'b1, 1'b0, 1'b0, 1'b0);
        frame_n = 1'b1; irdy_n = 1'b0; idsel = 1'b0; cbe_n = 4'h0; ad_in = 32'hDEADBEEF;
        step();
        chk_bus("wr_wstb", 1'b1, 1'b1, 1'b1, 1'b0);
        chk1("wr_wstb_en", cfg_enable, 1'b1);
        chk1("wr_wstb_stop_n", stop_n_out, 1'b1);
        idle_bus();
        step();
        chk_bus("wr_idle", 1'b0, 1'b1, 1'b1, 1'b0);
        chk1("wr_idle_en", cfg_enable, 1'b0);
        chk1("wr_par_oe", par_oe, 1'b0);

        // 3: non-claimed address phases followed by a claim-looking data phase
        for (int n = 0; n < 4; n++) begin
            addr_phase(nc_cmd[n], nc_ad[n], nc_sel[n]);
            step();
            chk_bus("nc_addr", 1'b0, 1'b1, 1'b1, 1'b0);
            frame_n = 1'b0; irdy_n = 1'b0; idsel = 1'b1; cbe_n = CMD_CFG_READ; ad_in = 32'd0;
            step();
            chk_bus("nc_data", 1'b0, 1'b1, 1'b1, 1'b0);
            frame_n = 1'b1; irdy_n = 1'b0;
            step();
            chk1("nc_last_ctl_oe", ctl_oe, 1'b0);
            idle_bus();
            step();
            chk1("nc_idle_ctl_oe", ctl_oe, 1'b0);
        end

        // 4: read with three IRDY# wait states
        read_txn(6'd2, 32'hA5A50F0F, 3);

        // 5: read with FRAME# held into the data phase -> disconnect, then BUSY
        push(1'b0, 6'd3, 32'd0);
        addr_phase(CMD_CFG_READ, 32'h0000000C, 1'b1);
        step();
        frame_n = 1'b0; irdy_n = 1'b0; idsel = 1'b0; cbe_n = 4'h0; ad_in = 32'd0;
        step();
        step();
        chk_bus("dc_data", 1'b1, 1'b0, 1'b0, 1'b1);
        chk1("dc_stop_n", stop_n_out, 1'b0);
        chk32("dc_ad_out", ad_out, 32'h0F1E2D3C);
        step();
        chk_bus("dc_turn", 1'b1, 1'b1, 1'b1, 1'b0);
        chk1("dc_turn_stop_n", stop_n_out, 1'b1);
        chk1("dc_turn_par", par_out, ^{32'h0F1E2D3C, 4'h0});
        step();
        chk1("dc_busy_ctl_oe", ctl_oe, 1'b0);
        frame_n = 1'b0; irdy_n = 1'b0; idsel = 1'b1; cbe_n = CMD_CFG_READ; ad_in = 32'd0;
        step();
        chk_bus("dc_busy_data", 1'b0, 1'b1, 1'b1, 1'b0);
        frame_n = 1'b1; irdy_n = 1'b0; idsel = 1'b0; cbe_n = 4'h0;
        step();
        chk1("dc_busy_last", ctl_oe, 1'b0);
        frame_n = 1'b0; irdy_n = 1'b1; idsel = 1'b1; cbe_n = CMD_CFG_READ; ad_in = 32'd0;
        step();
        chk_bus("dc_busy_hold", 1'b0, 1'b1, 1'b1, 1'b0);
        idle_bus();
        step();
        chk1("dc_idle_ctl_oe", ctl_oe, 1'b0);
        step();

        // 6: asynchronous reset in RDATA, then a normal read
        push(1'b0, 6'd4, 32'd0);
        addr_phase(CMD_CFG_READ, 32'h00000010, 1'b1);
        step();
        frame_n = 1'b1; irdy_n = 1'b1; idsel = 1'b0; cbe_n = 4'h0; ad_in = 32'd0;
        step();
        step();
        chk1("ar_rdata_ad_oe", ad_oe, 1'b1);
        chk32("ar_rdata_ad_out", ad_out, 32'hCAFEF00D);
        step();
        chk1("ar_rdata_par_oe", par_oe, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bus("ar_rst", 1'b0, 1'b1, 1'b1, 1'b0);
        chk1("ar_rst_par_oe", par_oe, 1'b0);
        chk1("ar_rst_stop_n", stop_n_out, 1'b1);
        step();
        step();
        chk1("ar_hold_en", cfg_enable, 1'b0);
        rst_n = 1'b1;
        step();
        read_txn(6'd0, 32'h12345678, 0);

        step();
        chk1("sb_empty", exp_q.size() == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
